// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider (RISC-V DIV/DIVU/REM/REMU plus W-forms), STEPS quotient bits per cycle.
// Optional early-out for |a| < |b| when DIV_EARLY_OUT_EN is defined.
module iter_divider #(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            is_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = 7;
    localparam int SH = XLEN - 32;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] prem_q, prem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] x);
        sx32 = $signed(x << SH) >>> SH;
    endfunction

    function automatic logic [XLEN-1:0] zx32(input logic [XLEN-1:0] x);
        zx32 = (x << SH) >> SH;
    endfunction

    // Operand preparation at acceptance
    logic            word_in, neg_a, neg_b, b_zero, ovf;
    logic [XLEN-1:0] a_n, b_n, a_ext, mag_a, mag_b, min_n;

    always_comb begin
        word_in = (XLEN == 64) && is_word;
        a_n     = word_in ? (is_signed ? sx32(a) : zx32(a)) : a;
        b_n     = word_in ? (is_signed ? sx32(b) : zx32(b)) : b;
        a_ext   = word_in ? sx32(a) : a;
        neg_a   = is_signed & a_n[XLEN-1];
        neg_b   = is_signed & b_n[XLEN-1];
        mag_a   = neg_a ? -a_n : a_n;
        mag_b   = neg_b ? -b_n : b_n;
        b_zero  = (b_n == '0);
        min_n   = word_in ? sx32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        ovf     = is_signed & (a_n == min_n) & (b_n == '1);
    end

    // STEPS chained shift/compare/subtract stages; dividend is left-aligned so its MSB feeds in first
    logic [XLEN-1:0] st_rem [0:STEPS];
    logic [XLEN-1:0] st_dvd [0:STEPS];

    assign st_rem[0] = prem_q;
    assign st_dvd[0] = dvd_q;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            logic [XLEN:0] shifted;
            logic          ge;
            assign shifted        = {st_rem[gi], st_dvd[gi][XLEN-1]};
            assign ge             = shifted >= {1'b0, div_q};
            assign st_rem[gi+1]   = XLEN'(ge ? shifted - {1'b0, div_q} : shifted);
            assign st_dvd[gi+1]   = {st_dvd[gi][XLEN-2:0], ge};
        end
    endgenerate

    logic [XLEN-1:0] q_raw, r_raw, q_fix, r_fix;

    always_comb begin
        q_raw = word_q ? zx32(dvd_q) : dvd_q;
        r_raw = prem_q;
        q_fix = negq_q ? -q_raw : q_raw;
        r_fix = negr_q ? -r_raw : r_raw;
        if (word_q) begin
            q_fix = sx32(q_fix);
            r_fix = sx32(r_fix);
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        word_d  = word_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    word_d = word_in;
                    negq_d = is_signed & (neg_a ^ neg_b) & !b_zero;
                    negr_d = neg_a;
                    div_d  = mag_b;
                    prem_d = '0;
                    dvd_d  = word_in ? (mag_a << SH) : mag_a;
                    if (b_zero) begin
                        quo_d   = '1;
                        rem_d   = a_ext;
                        state_d = DONE;
                    end else if (ovf) begin
                        quo_d   = a_n;
                        rem_d   = '0;
                        state_d = DONE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (mag_a < mag_b) begin
                        quo_d   = '0;
                        rem_d   = a_ext;
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d   = word_in ? CW'(32 / STEPS) : CW'(XLEN / STEPS);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = st_rem[STEPS];
                dvd_d  = st_dvd[STEPS];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIXUP;
            end
            FIXUP: begin
                quo_d   = q_fix;
                rem_d   = r_fix;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            div_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            word_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule
